// File: rtl/uart_hex_dump_tx.sv
// Memory hex dump over UART: reads 32-bit words and sends them as ASCII hex lines (8N1).
// Optional `DUMP_ADDR_PREFIX_EN prefixes each line with "AA:" (word address, 2 hex chars).
module uart_hex_dump_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

`ifdef DUMP_ADDR_PREFIX_EN
    localparam int PFX_CHARS = 3;
`else
    localparam int PFX_CHARS = 0;
`endif
    localparam int LINE_CHARS = PFX_CHARS + 10;
    localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       CHAR_LAST = 4'(LINE_CHARS - 1);
    localparam logic [3:0]       BIT_STOP  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SEND_CHAR,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_left_q, words_left_d;
    logic [3:0]        char_idx_q, char_idx_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0]        cur_char;
    logic [2:0]        nib_sel;
    logic [4:0]        nib_shamt;
    logic [3:0]        data_nib;
    logic [2:0]        bit_sel;
    logic              bit_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character currently on the wire, selected by position within the line.
    always_comb begin
        nib_sel   = 3'(char_idx_q - 4'(PFX_CHARS));
        nib_shamt = 5'd28 - {nib_sel, 2'b00};
        data_nib  = word_q[nib_shamt +: 4];
        cur_char  = hex_ascii(data_nib);
        if (char_idx_q == CHAR_LAST) begin
            cur_char = 8'h0A;
        end else if (char_idx_q == CHAR_LAST - 4'd1) begin
            cur_char = 8'h0D;
        end
`ifdef DUMP_ADDR_PREFIX_EN
        else if (char_idx_q == 4'd0) begin
            cur_char = hex_ascii(8'(addr_q) >> 4);
        end else if (char_idx_q == 4'd1) begin
            cur_char = hex_ascii(4'(addr_q));
        end else if (char_idx_q == 4'd2) begin
            cur_char = 8'h3A;
        end
`endif
    end

    // Serial line decoded from registered state; idle/reset state is high.
    always_comb begin
        bit_sel = 3'(bit_idx_q - 4'd1);
        tx      = 1'b1;
        if (state_q == S_SEND_CHAR) begin
            if (bit_idx_q == 4'd0) begin
                tx = 1'b0;
            end else if (bit_idx_q != BIT_STOP) begin
                tx = cur_char[bit_sel];
            end
        end
    end

    // Next-char and next-word decisions are taken in the last cycle of each
    // stop bit, so frames within a line and the FETCH/CAPTURE gap are seamless.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        char_idx_d   = char_idx_q;
        bit_idx_d    = bit_idx_q;
        baud_cnt_d   = baud_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        bit_end      = (baud_cnt_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = S_FETCH;
                        busy_d       = 1'b1;
                        addr_d       = base_addr;
                        words_left_d = num_words;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d    = S_SEND_CHAR;
                word_d     = rd_data;
                char_idx_d = 4'd0;
                bit_idx_d  = 4'd0;
                baud_cnt_d = '0;
            end
            S_SEND_CHAR: begin
                if (!bit_end) begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end else begin
                    baud_cnt_d = '0;
                    if (bit_idx_q != BIT_STOP) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else begin
                        bit_idx_d = 4'd0;
                        if (char_idx_q != CHAR_LAST) begin
                            char_idx_d = char_idx_q + 4'd1;
                        end else begin
                            char_idx_d   = 4'd0;
                            addr_d       = addr_q + 1'b1;
                            words_left_d = words_left_q - 1'b1;
                            if (words_left_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                                state_d = S_FINISH;
                            end else begin
                                state_d = S_FETCH;
                            end
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            addr_q       <= '0;
            words_left_q <= '0;
            char_idx_q   <= '0;
            bit_idx_q    <= '0;
            baud_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            char_idx_q   <= char_idx_d;
            bit_idx_q    <= bit_idx_d;
            baud_cnt_q   <= baud_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rd_en   = (state_q == S_FETCH);
    assign rd_addr = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_uart_hex_dump_tx.sv
// Bench for uart_hex_dump_tx: a line/frame model expands each dump into a
// per-cycle expectation of tx/busy/done/rd_en/rd_addr, checked every cycle.
module tb_uart_hex_dump_tx;
    localparam int CPB = 4;
    localparam int AW  = 4;
`ifdef DUMP_ADDR_PREFIX_EN
    localparam int LAT1 = 523;
`else
    localparam int LAT1 = 403;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          rd_en, tx, busy, done;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [31:0]   mem [16];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic       tx;
        logic       busy;
        logic       done;
        logic       rden;
        logic [3:0] addr;
    } cyc_t;

    cyc_t       exp_q [$];
    logic [7:0] chr_q [$];

    always #5 clk = ~clk;

    uart_hex_dump_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
    );

    // Memory answers one cycle after rd_en; garbage otherwise.
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : $urandom();

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic cyc_t mk(logic t, logic b, logic d, logic r, logic [3:0] a);
        cyc_t c;
        c.tx = t; c.busy = b; c.done = d; c.rden = r; c.addr = a;
        return c;
    endfunction

    function automatic logic [7:0] hexc(int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    // Model: text lines -> 8N1 frames -> per-cycle expectation, starting at
    // the first cycle after the accepting edge.
    task automatic model_dump(int base, int num);
        chr_q.delete();
        if (num == 0) begin
            exp_q.push_back(mk(1, 0, 1, 0, 0));
            return;
        end
        for (int w = 0; w < num; w++) begin
            int         a;
            logic [7:0] line [$];
            a = (base + w) % 16;
            exp_q.push_back(mk(1, 1, 0, 1, 4'(a)));
            exp_q.push_back(mk(1, 1, 0, 0, 0));
`ifdef DUMP_ADDR_PREFIX_EN
            line.push_back(hexc(a / 16));
            line.push_back(hexc(a % 16));
            line.push_back(8'h3A);
`endif
            for (int n = 7; n >= 0; n--) line.push_back(hexc(int'((mem[a] >> (4 * n)) & 32'hF)));
            line.push_back(8'h0D);
            line.push_back(8'h0A);
            foreach (line[i]) begin
                chr_q.push_back(line[i]);
                for (int b = 0; b < 10; b++) begin
                    logic bitv;
                    bitv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : line[i][b-1];
                    repeat (CPB) exp_q.push_back(mk(bitv, 1, 0, 0, 0));
                end
            end
        end
        exp_q.push_back(mk(1, 1, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 1, 0, 0));
    endtask

    always @(negedge clk) begin : cmp
        cyc_t e, a;
        if (chk_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1, 0, 0, 0, 0);
            a = mk(tx, busy, done, rd_en, e.rden ? rd_addr : 4'd0);
            check("cycle{tx,busy,done,rd_en,addr}", a, e);
        end
    end

    task automatic do_start(int b, int n);
        @(negedge clk);
        start = 1'b1; base_addr = AW'(b); num_words = (AW+1)'(n);
        @(posedge clk);
        #1 start = 1'b0;
        model_dump(b, n);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("dump_within_budget", exp_q.size() == 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_chars(string name, string s);
        check({name, "_len"}, chr_q.size(), s.len());
        for (int i = 0; i < s.len() && i < chr_q.size(); i++) check(name, chr_q[i], s[i]);
    endtask

    initial begin
        int n;
        string s1, s2;
        foreach (mem[i]) mem[i] = 32'h0;
`ifdef DUMP_ADDR_PREFIX_EN
        s1 = {"00:1234ABCD", "\015\012"};
        s2 = {"0E:00000000", "\015\012", "0F:FFFFFFFF", "\015\012", "00:00000009", "\015\012"};
`else
        s1 = {"1234ABCD", "\015\012"};
        s2 = {"00000000", "\015\012", "FFFFFFFF", "\015\012", "00000009", "\015\012"};
`endif
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // 1: single word, latency to done
        mem[0] = 32'h1234ABCD;
        do_start(0, 1);
        check_chars("t1_chars", s1);
        check("t1_model_len", exp_q.size(), LAT1 + 1);
        n = -1;
        do begin @(negedge clk); n++; end while (!done && n < 1000);
        check("t1_done_latency", n, LAT1);
        wait_idle();

        // 2: address wrap, three lines
        mem[14] = 32'h0; mem[15] = 32'hFFFFFFFF; mem[0] = 32'h9;
        do_start(14, 3);
        check_chars("t2_chars", s2);
        wait_idle();

        // 3: empty dump
        do_start(0, 0);
        wait_idle();

        // 4: start while busy is ignored
        mem[0] = 32'h1234ABCD; mem[5] = 32'h55555555;
        do_start(0, 1);
        repeat (100) @(negedge clk);
        start = 1'b1; base_addr = 4'd5; num_words = 5'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // 5: reset during data bit 3 of the second character ('2' = 0x32)
        do_start(0, 1);
        repeat (59) @(negedge clk);
        check("t5_pre_reset_tx", tx, 0);
        check("t5_pre_reset_busy", busy, 1);
        #2;
        chk_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        mem[0] = 32'h1234ABCD;
        do_start(0, 1);
        check_chars("t5_chars", s1);
        wait_idle();

`ifdef DUMP_ADDR_PREFIX_EN
        // 6: address prefix
        mem[10] = 32'hCAFE0001;
        do_start(10, 1);
        check_chars("t6_chars", {"0A:CAFE0001", "\015\012"});
        wait_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
